// File: rtl/adder_4bit_if.sv
// rtl/adder_4bit_if.sv - operand/result bundle for the registered 4-bit adder
interface adder_4bit_if;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic       Cout;
    logic [3:0] Sum;

    modport master (
        output A,
        output B,
        output Cin,
        input  Cout,
        input  Sum
    );

    modport slave (
        input  A,
        input  B,
        input  Cin,
        output Cout,
        output Sum
    );
endinterface

// File: rtl/adder_4bit.sv
// rtl/adder_4bit.sv - 4-bit carry-lookahead adder with a registered {Cout, Sum}
module adder_4bit (
    input  logic        clk,
    input  logic        rst_n,
    adder_4bit_if.slave bus
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] sum_d;
    logic       cout_d;
    logic [3:0] sum_q;
    logic       cout_q;

    assign g = bus.A & bus.B;
    assign p = bus.A ^ bus.B;

    // Each carry is a flat sum of products of g, p and Cin so no carry waits on another.
    assign c[0] = bus.Cin;
    assign c[1] = g[0] | (p[0] & bus.Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bus.Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bus.Cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & bus.Cin);

    assign sum_d  = p ^ c[3:0];
    assign cout_d = c[4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= 4'b0000;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
endmodule

// File: tb/tb_adder_4bit.sv
// tb/tb_adder_4bit.sv - scoreboard bench for adder_4bit
module tb_adder_4bit;
    logic clk;
    logic rst_n;
    adder_4bit_if bus ();

    adder_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [4:0] exp_q[$];
    logic [4:0] last_exp;
    bit         have_last = 0;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got {Cout,Sum}=%b_%b required %b_%b",
                      tag, got[4], got[3:0], exp[4], exp[3:0]);
    endtask

    // Drive one vector right after an edge, push the model result, then pop and
    // compare once the capturing edge has passed.
    task automatic step(input string tag, input logic rst, input logic [3:0] a,
                        input logic [3:0] b, input logic ci);
        logic [4:0] exp;
        logic [4:0] got;
        rst_n   = rst;
        bus.A   = a;
        bus.B   = b;
        bus.Cin = ci;
        exp_q.push_back(rst ? ({1'b0, a} + {1'b0, b} + {4'b0, ci}) : 5'd0);
        if (have_last) begin
            @(negedge clk);
            check({tag, "_hold"}, {bus.Cout, bus.Sum}, last_exp);
        end
        @(posedge clk);
        #1;
        got = {bus.Cout, bus.Sum};
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = exp_q.pop_front();
            check(tag, got, exp);
            last_exp  = exp;
            have_last = 1;
        end
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;

        step("rst0", 1'b0, 4'd9, 4'd7, 1'b1);
        step("rst1", 1'b0, 4'd9, 4'd7, 1'b1);
        step("3p5", 1'b1, 4'd3, 4'd5, 1'b0);
        step("wrap", 1'b1, 4'd15, 4'd1, 1'b0);
        step("max", 1'b1, 4'd15, 4'd15, 1'b1);
        step("cin_only", 1'b1, 4'd0, 4'd0, 1'b1);
        step("8p8", 1'b1, 4'd8, 4'd8, 1'b0);
        step("b2b_a", 1'b1, 4'd2, 4'd2, 1'b0);
        step("b2b_b", 1'b1, 4'd7, 4'd9, 1'b1);
        step("mid_rst", 1'b0, 4'd6, 4'd5, 1'b1);
        step("post_rst", 1'b1, 4'd6, 4'd5, 1'b1);
        step("10p5", 1'b1, 4'd10, 4'd5, 1'b0);

        for (int i = 0; i < 16; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            step($sformatf("rand%0d", i), 1'b1, ra, rb, rc);
            $display("vec %0d: A=%0d B=%0d Cin=%0d -> Cout=%0d Sum=%0d",
                     i, ra, rb, rc, bus.Cout, bus.Sum);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
